// File: rtl/lock_input_conditioner_pkg.sv
// Shared constants for the lock front end: channel counts, button indices and
// the default debounce interval.
package lock_io_pkg;

  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_OOPS  = 1;
  localparam int unsigned BTN_RESET = 2;

  localparam int unsigned N_BTN = 3;
  localparam int unsigned N_SW  = 4;

endpackage

// File: rtl/lock_input_conditioner_if.sv
// Raw board inputs and their conditioned counterparts; the board side is the
// master, the conditioner is the slave.
interface lock_input_conditioner_if #(
  parameter int unsigned N_BTN = lock_io_pkg::N_BTN,
  parameter int unsigned N_SW  = lock_io_pkg::N_SW
) ();

  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_snap;
  logic             snap_strobe;

  modport master (
    output btn_raw, sw_raw,
    input  btn_level, btn_press, sw_stable, sw_snap, snap_strobe
  );

  modport slave (
    input  btn_raw, sw_raw,
    output btn_level, btn_press, sw_stable, sw_snap, snap_strobe
  );

endinterface

// File: rtl/lock_input_conditioner_debounce_ch.sv
// One input channel: 2-flop synchroniser, consecutive-cycle debounce counter
// and a registered strobe on each debounced rising edge.
module debounce_ch #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned            CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // press rides the same edge as the 0->1 flip of level
        level <= s2;
        press <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_input_conditioner.sv
// Conditions pushbuttons and switches for the lock FSM and captures the
// switch word one cycle after each enter press.
module lock_input_conditioner
  import lock_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned N_BTN     = lock_io_pkg::N_BTN,
  parameter int unsigned N_SW      = lock_io_pkg::N_SW,
  parameter int unsigned SNAP_IDX  = BTN_ENTER
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lock_input_conditioner_if.slave    io
);

  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_press_unused;
  logic [N_SW-1:0]  sw_snap;
  logic             snap_strobe;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (io.btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (io.sw_raw[i]),
      .level (sw_stable[i]),
      .press (sw_press_unused[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_snap     <= '0;
      snap_strobe <= 1'b0;
    end else begin
      snap_strobe <= btn_press[SNAP_IDX];
      if (btn_press[SNAP_IDX]) begin
        sw_snap <= sw_stable;
      end
    end
  end

  assign io.btn_level   = btn_level;
  assign io.btn_press   = btn_press;
  assign io.sw_stable   = sw_stable;
  assign io.sw_snap     = sw_snap;
  assign io.snap_strobe = snap_strobe;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Randomised and directed stimulus for lock_input_conditioner, checked against
// a sliding-window reference model of the debounce rules.
module tb_lock_input_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned NB   = 3;
  localparam int unsigned NS   = 4;
  localparam int unsigned NC   = NB + NS;
  localparam int unsigned SNAP = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lock_input_conditioner_if #(.N_BTN(NB), .N_SW(NS)) ifc ();

  lock_input_conditioner #(
    .DB_CYCLES (DB),
    .N_BTN     (NB),
    .N_SW      (NS),
    .SNAP_IDX  (SNAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: raw samples per channel, newest in bit 0
  logic [DB+1:0]   hist [NC];
  logic [NC-1:0]   m_lvl;
  logic [NC-1:0]   m_press;
  logic [NS-1:0]   m_snap;
  logic            m_strobe;

  logic [NB-1:0]   cur_b = '0;
  logic [NS-1:0]   cur_s = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) hist[c] = '0;
    m_lvl    = '0;
    m_press  = '0;
    m_snap   = '0;
    m_strobe = 1'b0;
  endtask

  // a channel takes the value v once the synchronised input (raw two edges ago)
  // has shown v for DB consecutive edges while the level was !v
  task automatic model_edge(input logic [NB-1:0] b, input logic [NS-1:0] s);
    logic [NC-1:0] r;
    logic [DB-1:0] win;
    if (!rst_n) begin
      model_clear();
    end else begin
      r = {s, b};
      m_strobe = m_press[SNAP];
      if (m_press[SNAP]) m_snap = m_lvl[NC-1:NB];
      m_press = '0;
      for (int c = 0; c < NC; c++) begin
        hist[c] = {hist[c][DB:0], r[c]};
        win = hist[c][DB+1:2];
        if (!m_lvl[c] && win == '1) begin
          m_lvl[c]   = 1'b1;
          m_press[c] = 1'b1;
        end else if (m_lvl[c] && win == '0) begin
          m_lvl[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("btn_level",   32'(ifc.btn_level),   32'(m_lvl[NB-1:0]));
    check("btn_press",   32'(ifc.btn_press),   32'(m_press[NB-1:0]));
    check("sw_stable",   32'(ifc.sw_stable),   32'(m_lvl[NC-1:NB]));
    check("sw_snap",     32'(ifc.sw_snap),     32'(m_snap));
    check("snap_strobe", 32'(ifc.snap_strobe), 32'(m_strobe));
  endtask

  // inputs change just after a rising edge; outputs sampled 1 time unit after
  task automatic step(input logic [NB-1:0] b, input logic [NS-1:0] s);
    ifc.btn_raw = b;
    ifc.sw_raw  = s;
    @(posedge clk);
    model_edge(b, s);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(cur_b, cur_s);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    model_clear();
    #1;
    compare_all();
    run(n);
    rst_n = 1'b1;
  endtask

  task automatic steps_until_press(input int idx, input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      step(cur_b, cur_s);
      if (ifc.btn_press[idx] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt_press;
    ifc.btn_raw = '0;
    ifc.sw_raw  = '0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset(3);
    check("reset_outputs", 32'({ifc.btn_level, ifc.btn_press, ifc.sw_stable, ifc.sw_snap, ifc.snap_strobe}), 32'd0);
    run(8);

    // clean press on enter
    cur_b[0] = 1'b1;
    steps_until_press(0, 20, n);
    check("clean_latency", 32'(n), 32'd6);
    check("clean_level", 32'(ifc.btn_level[0]), 32'd1);
    step(cur_b, cur_s);
    check("clean_single", 32'(ifc.btn_press[0]), 32'd0);
    check("clean_snap_strobe", 32'(ifc.snap_strobe), 32'd1);
    step(cur_b, cur_s);
    check("clean_strobe_once", 32'(ifc.snap_strobe), 32'd0);
    run(14);
    cur_b[0] = 1'b0;
    run(10);
    check("release_level", 32'(ifc.btn_level[0]), 32'd0);

    // bounce on oops: 1,0,1,0 then hold 1
    cnt_press = 0;
    for (int k = 0; k < 4; k++) begin
      cur_b[1] = (k % 2 == 0);
      step(cur_b, cur_s);
      cnt_press += int'(ifc.btn_press[1]);
    end
    cur_b[1] = 1'b1;
    steps_until_press(1, 20, n);
    check("bounce_no_early", 32'(cnt_press), 32'd0);
    check("bounce_latency", 32'(n), 32'd6);
    cur_b[1] = 1'b0;
    run(10);

    // 3-cycle glitch on reset button
    cnt_press = 0;
    cur_b[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(cur_b, cur_s);
      cnt_press += int'(ifc.btn_press[2]);
    end
    cur_b[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(cur_b, cur_s);
      cnt_press += int'(ifc.btn_press[2]);
      check("glitch_level", 32'(ifc.btn_level[2]), 32'd0);
    end
    check("glitch_no_press", 32'(cnt_press), 32'd0);

    // snapshot then switch change without enter
    cur_s = 4'b1001;
    run(10);
    cur_b[0] = 1'b1;
    steps_until_press(0, 20, n);
    check("snap_press_latency", 32'(n), 32'd6);
    step(cur_b, cur_s);
    check("snap_strobe", 32'(ifc.snap_strobe), 32'd1);
    check("snap_value", 32'(ifc.sw_snap), 32'h9);
    cur_b[0] = 1'b0;
    cur_s = 4'b0110;
    run(12);
    check("snap_hold", 32'(ifc.sw_snap), 32'h9);
    check("sw_new_stable", 32'(ifc.sw_stable), 32'h6);

    // simultaneous presses
    cur_b = 3'b111;
    steps_until_press(0, 20, n);
    check("simul_press", 32'(ifc.btn_press), 32'h7);
    step(cur_b, cur_s);
    check("simul_clear", 32'(ifc.btn_press), 32'h0);
    cur_b = '0;
    run(10);

    // reset with a count in progress, button held through release
    cur_b[0] = 1'b1;
    run(4);
    apply_reset(2);
    check("rst_mid_outputs", 32'({ifc.btn_level, ifc.btn_press, ifc.sw_stable, ifc.sw_snap, ifc.snap_strobe}), 32'd0);
    steps_until_press(0, 20, n);
    check("rst_mid_latency", 32'(n), 32'd6);
    cur_b = '0;
    run(10);

    // random toggling with occasional resets
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NB; c++) if ($urandom_range(5, 0) == 0) cur_b[c] = ~cur_b[c];
      for (int c = 0; c < NS; c++) if ($urandom_range(7, 0) == 0) cur_s[c] = ~cur_s[c];
      if ($urandom_range(499, 0) == 0) apply_reset(int'($urandom_range(3, 1)));
      else step(cur_b, cur_s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lock_input_conditioner.md
Name: lock_input_conditioner

Overview:
- Upstream front end for the combination-lock FSM on the Arty A7-35T.
- Takes the raw board pushbuttons (enter, oops, reset) and the 4 login slide switches.
- Synchronises and debounces every input.
- Produces single-cycle press strobes, plus a switch snapshot captured on each enter press, so the lock FSM sees exactly one clean event per physical press with a stable login value aligned to it.

Parameters:
- DB_CYCLES, 1_000_000, consecutive clk cycles a synchronised input must differ from its debounced state before the state flips (10 ms at 100 MHz); legal range >= 2.
- N_BTN, 3, number of pushbutton channels.
- N_SW, 4, number of switch channels.
- SNAP_IDX, 0, button index whose press captures the switch snapshot (enter).

Ports:
- clk  in  1  system clock, 100 MHz board clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw pushbutton pins, asynchronous to clk, bouncing.
- sw_raw  in  N_SW  raw slide-switch pins, asynchronous, bouncing.
- btn_level  out  N_BTN  debounced button levels.
- btn_press  out  N_BTN  one-cycle strobe on each debounced 0->1 edge.
- sw_stable  out  N_SW  debounced switch levels.
- sw_snap  out  N_SW  sw_stable captured on btn_press[SNAP_IDX].
- snap_strobe  out  1  one-cycle strobe; sw_snap is valid and new in that cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n is low, every flop is cleared: sync stages, counters, btn_level, btn_press, sw_stable, sw_snap and snap_strobe all = 0.
- Synchroniser: each raw bit passes through a 2-flop synchroniser (s1, s2) before any other logic. No raw bit feeds combinational logic.
- Debounce, per channel: registers stable and cnt (width $clog2(DB_CYCLES)).
  - If s2 == stable: cnt <= 0.
  - If s2 != stable and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - If s2 != stable and cnt == DB_CYCLES-1: stable <= s2 and cnt <= 0.
- Latency: raw input changes cleanly before edge 1. stable flips at edge DB_CYCLES+2 and is visible in the following cycle.
- Glitch rejection: any excursion of s2 lasting fewer than DB_CYCLES cycles resets cnt and produces no change. Bounces restart the count.
- btn_press[i]:
  - Registered; set at the same edge where stable[i] goes 0->1, so it is high in the first cycle btn_level[i] is 1.
  - Cleared the next edge, giving exactly 1 cycle per press.
  - No strobe on release. No repeat while held.
- Snapshot:
  - At the edge after btn_press[SNAP_IDX]==1: sw_snap <= sw_stable and snap_strobe <= 1.
  - snap_strobe clears on the following edge.
  - sw_snap holds its value until the next capture.
  - Downstream uses snap_strobe as enter and sw_snap as login.
- Switch channels use the identical debounce path and have no press strobe.
- Simultaneous events: channels are fully independent. Presses on several buttons in the same cycle give simultaneous strobes. A switch change coincident with the enter press is not in the snapshot unless sw_stable had already flipped in an earlier cycle.
- Reset mid-operation: partial counts are discarded and no strobe is emitted. If a button is held through reset release, stable is still 0 after reset, so a press fires DB_CYCLES+2 edges after release. Intended: it counts as a new press.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package lock_io_pkg holds:
  - DB_CYCLES_DEFAULT = 1_000_000.
  - Button indices BTN_ENTER=0, BTN_OOPS=1, BTN_RESET=2.
  - Constants N_BTN=3, N_SW=4.
- Sub-module debounce_ch (single-bit synchroniser + debounce + rising-edge strobe, parameter DB_CYCLES) is instantiated N_BTN+N_SW times. The snapshot logic stays in the top module.

Test Plan (all with DB_CYCLES=4):
- Clean press: btn_raw[0] 0->1 held 20 cycles -> btn_level[0] rises at edge 6, btn_press[0] high exactly 1 cycle, snap_strobe high 1 cycle later.
- Bounce: btn_raw[1] toggles 1,0,1,0 each cycle, then holds 1 -> exactly one btn_press[1], at edge 6 counted from the final rising transition; no strobes during bounce.
- Glitch: 3-cycle high pulse on btn_raw[2] -> btn_level[2] stays 0, no strobe.
- Snapshot: sw_raw=4'b1001 settled 10 cycles, then enter pressed -> sw_snap=4'b1001 with snap_strobe. Then change sw_raw to 4'b0110 without pressing -> sw_snap stays 1001.
- Simultaneous: btn_raw=3'b111 in one cycle -> btn_press=3'b111 for exactly one cycle.
- Reset mid-count: assert rst_n low at cnt=2 while btn held, release -> all outputs 0; btn_press fires 6 edges after release.
